seq_shift_add_multiplier: RTL and testbench

//  Multi-cycle shift-add multiplier for the ALU datapath, parametrised in operand width.

---
 rtl/seq_shift_add_multiplier_if.sv | 23 ++
 rtl/seq_shift_add_multiplier.sv | 88 ++++++++
 tb/tb_seq_shift_add_multiplier.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_shift_add_multiplier_if.sv
// Operand/result bundle between the control unit and the shift-add multiplier.
// The master launches a multiply and reads back busy/done/dataOut.
interface seq_shift_add_multiplier_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic                   sign_mode;
    logic [WIDTH-1:0]       dataA;
    logic [WIDTH-1:0]       dataB;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     dataOut;

    modport master (
        output start, sign_mode, dataA, dataB,
        input  busy, done, dataOut
    );

    modport slave (
        input  start, sign_mode, dataA, dataB,
        output busy, done, dataOut
    );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Shift-add multiplier (MULT/MULTU): one adder, WIDTH add/shift iterations per product.
// Latency: start edge k -> dataOut/done at edge k+WIDTH+1; one result per WIDTH+3 cycles.
// Backpressure: none; start is ignored while busy, nothing is queued.
module seq_shift_add_multiplier #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic clk,
    input  logic reset,
    seq_shift_add_multiplier_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     hi;
    logic [WIDTH-1:0]     lo;
    logic                 neg;
    logic [CNT_W-1:0]     cnt;

    logic [WIDTH-1:0]     a_in;
    logic [WIDTH-1:0]     b_in;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   prod;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CALC;
            CALC:    if (cnt == LAST) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != IDLE);
        bus.done = (state == DONE);
    end

    // Magnitude of the most-negative value wraps to itself, which is the correct unsigned magnitude.
    always_comb begin
        a_in = (bus.sign_mode && bus.dataA[WIDTH-1]) ? -bus.dataA : bus.dataA;
        b_in = (bus.sign_mode && bus.dataB[WIDTH-1]) ? -bus.dataB : bus.dataB;
        sum  = lo[0] ? ({1'b0, hi} + {1'b0, a_mag}) : {1'b0, hi};
        prod = {hi, lo};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_mag       <= '0;
            hi          <= '0;
            lo          <= '0;
            neg         <= 1'b0;
            cnt         <= '0;
            bus.dataOut <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_mag <= a_in;
                        hi    <= '0;
                        lo    <= b_in;
                        neg   <= bus.sign_mode & (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1]);
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    // The carry out of the add lands in hi's MSB after the shift.
                    hi  <= sum[WIDTH:1];
                    lo  <= {sum[0], lo[WIDTH-1:1]};
                    cnt <= cnt + CNT_W'(1);
                end
                FIX:     bus.dataOut <= neg ? -prod : prod;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
module tb_seq_shift_add_multiplier;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    seq_shift_add_multiplier_if #(.WIDTH(32)) bus32();
    seq_shift_add_multiplier_if #(.WIDTH(8))  bus8();

    seq_shift_add_multiplier #(.WIDTH(32), .CNT_W(6)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32)
    );

    seq_shift_add_multiplier #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one 32-bit op, scramble the inputs after the start edge, wait (bounded) for done.
    task automatic run32(input logic sm, input logic [31:0] a, input logic [31:0] b,
                         output int cyc, output logic [63:0] res);
        bus32.sign_mode = sm;
        bus32.dataA     = a;
        bus32.dataB     = b;
        bus32.start     = 1'b1;
        tick();
        bus32.start     = 1'b0;
        bus32.sign_mode = ~sm;
        bus32.dataA     = ~a;
        bus32.dataB     = b ^ 32'h5A5A_A5A5;
        cyc = 0;
        while (bus32.done !== 1'b1 && cyc < 60) begin
            tick();
            cyc++;
        end
        res = bus32.dataOut;
    endtask

    task automatic run8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                        output int cyc, output logic [15:0] res);
        bus8.sign_mode = sm;
        bus8.dataA     = a;
        bus8.dataB     = b;
        bus8.start     = 1'b1;
        tick();
        bus8.start     = 1'b0;
        bus8.dataA     = ~a;
        cyc = 0;
        while (bus8.done !== 1'b1 && cyc < 30) begin
            tick();
            cyc++;
        end
        res = bus8.dataOut;
    endtask

    initial begin
        int          cyc;
        logic [63:0] res;
        logic [15:0] res8;
        int          pulses;
        int          np;
        int          t;
        int          hold_bad;
        int          pulse_t [3];
        logic [63:0] exp_b2b [3];
        logic [63:0] last;

        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus32.start = 1'b0; bus32.sign_mode = 1'b0; bus32.dataA = '0; bus32.dataB = '0;
        bus8.start  = 1'b0; bus8.sign_mode  = 1'b0; bus8.dataA  = '0; bus8.dataB  = '0;
        tick();
        tick();
        check("rst_busy", 64'(bus32.busy), 64'd0);
        check("rst_done", 64'(bus32.done), 64'd0);
        check("rst_dout", bus32.dataOut, 64'd0);
        reset = 1'b1;
        tick();

        // Unsigned maximum operands, exact latency and single-cycle done.
        run32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, res);
        check("u_max_lat", 64'(cyc), 64'd33);
        check("u_max_res", res, 64'hFFFF_FFFE_0000_0001);
        tick();
        check("u_max_done_low", 64'(bus32.done), 64'd0);
        check("u_max_idle", 64'(bus32.busy), 64'd0);

        // Async reset mid-CALC clears outputs immediately and suppresses the result.
        bus32.sign_mode = 1'b0; bus32.dataA = 32'd7; bus32.dataB = 32'd9; bus32.start = 1'b1;
        tick();
        bus32.start = 1'b0;
        repeat (5) tick();
        #2 reset = 1'b0;
        #1;
        check("rst_mid_busy", 64'(bus32.busy), 64'd0);
        check("rst_mid_done", 64'(bus32.done), 64'd0);
        check("rst_mid_dout", bus32.dataOut, 64'd0);
        tick();
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus32.done === 1'b1) pulses++;
        end
        check("rst_no_done", 64'(pulses), 64'd0);

        // Signed cases.
        run32(1'b1, 32'hFFFF_FFFD, 32'd7, cyc, res);
        check("s_m3x7_lat", 64'(cyc), 64'd33);
        check("s_m3x7_res", res, 64'hFFFF_FFFF_FFFF_FFEB);
        tick();
        run32(1'b1, 32'h8000_0000, 32'h8000_0000, cyc, res);
        check("s_minmin_res", res, 64'h4000_0000_0000_0000);
        tick();
        run32(1'b1, 32'd0, 32'hFFFF_FFFB, cyc, res);
        check("s_zero_lat", 64'(cyc), 64'd33);
        check("s_zero_res", res, 64'd0);
        tick();

        // Start while busy is ignored.
        bus32.sign_mode = 1'b0; bus32.dataA = 32'd6; bus32.dataB = 32'd7; bus32.start = 1'b1;
        tick();
        bus32.start = 1'b0;
        repeat (10) tick();
        bus32.dataA = 32'd5; bus32.dataB = 32'd5; bus32.start = 1'b1;
        tick();
        bus32.start = 1'b0;
        pulses = 0;
        res = '0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus32.done === 1'b1) begin
                pulses++;
                res = bus32.dataOut;
            end
        end
        check("busy_ign_res", res, 64'd42);
        check("busy_ign_pulses", 64'(pulses), 64'd1);
        run32(1'b0, 32'd5, 32'd5, cyc, res);
        check("after_ign_res", res, 64'd25);
        tick();

        // Back-to-back with start held high.
        exp_b2b[0] = 64'd12;
        exp_b2b[1] = 64'd1000000;
        exp_b2b[2] = 64'h0000_0001_FFFF_FFFE;
        pulse_t[0] = 0; pulse_t[1] = 0; pulse_t[2] = 0;
        np = 0; t = 0; hold_bad = 0; last = '0;
        bus32.sign_mode = 1'b0; bus32.dataA = 32'd3; bus32.dataB = 32'd4; bus32.start = 1'b1;
        while (np < 3 && t < 200) begin
            tick();
            t++;
            if (bus32.done === 1'b1) begin
                pulse_t[np] = t;
                check("b2b_res", bus32.dataOut, exp_b2b[np]);
                last = bus32.dataOut;
                np++;
                if (np == 1) begin
                    bus32.dataA = 32'd1000; bus32.dataB = 32'd1000;
                end else if (np == 2) begin
                    bus32.dataA = 32'hFFFF_FFFF; bus32.dataB = 32'd2;
                end else begin
                    bus32.start = 1'b0;
                end
            end else if (np > 0 && bus32.dataOut !== last) begin
                hold_bad++;
            end
        end
        bus32.start = 1'b0;
        check("b2b_count", 64'(np), 64'd3);
        check("b2b_gap1", 64'(pulse_t[1] - pulse_t[0]), 64'd35);
        check("b2b_gap2", 64'(pulse_t[2] - pulse_t[1]), 64'd35);
        check("b2b_hold", 64'(hold_bad), 64'd0);
        repeat (4) tick();

        // WIDTH=8 instance.
        run8(1'b1, 8'h80, 8'hFF, cyc, res8);
        check("w8_s_lat", 64'(cyc), 64'd9);
        check("w8_s_res", 64'(res8), 64'h0080);
        tick();
        run8(1'b0, 8'hFF, 8'hFF, cyc, res8);
        check("w8_u_lat", 64'(cyc), 64'd9);
        check("w8_u_res", 64'(res8), 64'hFE01);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
